// File: rtl/serial_add_seq.sv
// ---------------------------------------------------------------------------
// serial_add_seq
//
// Bit-serial adder sequencer. Drives an external single-bit full-adder cell
// one operand bit per clock, LSB first, and assembles the returned sum bits
// into a WIDTH-bit result. One addition takes WIDTH RUN cycles followed by a
// single DONE cycle.
//
// Optional feature: define SERIAL_ADD_OVF_EN to add the signed-overflow
// output ovf (XOR of the carry into and out of the MSB position).
//
// Ports
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-high reset
//   start  in   request to begin an addition (honoured only in IDLE)
//   op_a   in   first operand, sampled on accepted start
//   op_b   in   second operand, sampled on accepted start
//   cin    in   initial carry, sampled on accepted start
//   fa_a   out  current LSB of the op_a shift register, to the cell
//   fa_b   out  current LSB of the op_b shift register, to the cell
//   fa_c   out  current carry register, to the cell
//   fa_y1  in   carry returned by the cell
//   fa_y0  in   sum bit returned by the cell
//   busy   out  high while in RUN
//   done   out  one-cycle pulse when sum/cout are valid
//   sum    out  result register, held until the next accepted start
//   cout   out  final carry, held like sum
//   ovf    out  signed overflow, held like sum (SERIAL_ADD_OVF_EN only)
// ---------------------------------------------------------------------------
module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_c,
    input  logic             fa_y1,
    input  logic             fa_y0,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    // Counter must be able to hold WIDTH itself so it never wraps.
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             c_reg;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sum_sh;

    // Cell drivers come straight from registers: no input-to-output path.
    assign fa_a = a_sh[0];
    assign fa_b = b_sh[0];
    assign fa_c = c_reg;

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            c_reg  <= 1'b0;
            cnt    <= '0;
            sum_sh <= '0;
            sum    <= '0;
            cout   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= op_a;
                        b_sh   <= op_b;
                        c_reg  <= cin;
                        cnt    <= '0;
                        sum_sh <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    // Sum bits arrive LSB first; shifting them in at the MSB
                    // leaves bit i at position i after WIDTH cycles.
                    sum_sh <= {fa_y0, sum_sh[WIDTH-1:1]};
                    c_reg  <= fa_y1;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        // Publish the result on the same edge that enters
                        // DONE, so sum/cout never move while RUN is active.
                        sum   <= {fa_y0, sum_sh[WIDTH-1:1]};
                        cout  <= fa_y1;
`ifdef SERIAL_ADD_OVF_EN
                        // c_reg is the carry into the MSB, fa_y1 the carry out.
                        ovf   <= c_reg ^ fa_y1;
`endif
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_seq.sv
// ---------------------------------------------------------------------------
// tb_serial_add_seq
//
// Directed bench for serial_add_seq (WIDTH=8) with a behavioural full-adder
// cell: y1 = majority(a,b,c), y0 = a^b^c. Covers reset state, several
// additions with latency/busy/hold checks, back-to-back operation with start
// held high, and reset abort during RUN. Define SERIAL_ADD_OVF_EN to also
// check the ovf output.
// ---------------------------------------------------------------------------
module tb_serial_add_seq;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             fa_a;
    logic             fa_b;
    logic             fa_c;
    logic             fa_y1;
    logic             fa_y0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #25 clk = ~clk;

    // Behavioural full-adder cell.
    assign fa_y1 = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);
    assign fa_y0 = fa_a ^ fa_b ^ fa_c;

    serial_add_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op_a  (op_a),
        .op_b  (op_b),
        .cin   (cin),
        .fa_a  (fa_a),
        .fa_b  (fa_b),
        .fa_c  (fa_c),
        .fa_y1 (fa_y1),
        .fa_y0 (fa_y0),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One complete addition from a single-cycle start pulse.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic c, input logic [7:0] exp_sum, input logic exp_cout,
                          input logic exp_ovf);
        int         n;
        int         bc;
        logic [7:0] s0;
        logic       moved;
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        cin   = c;
        start = 1'b1;
        n     = 0;
        bc    = 0;
        moved = 1'b0;
        @(posedge clk);
        #1;
        n     = 1;
        start = 1'b0;
        s0    = sum;
        if (busy) bc++;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (busy) begin
                bc++;
                if (sum !== s0) moved = 1'b1;
            end
        end
        check({tag, "_latency"}, 32'(n), 32'd9);
        check({tag, "_busy_cycles"}, 32'(bc), 32'd8);
        check({tag, "_sum_stable_in_run"}, 32'(moved), 32'd0);
        check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
        check({tag, "_cout"}, 32'(cout), 32'(exp_cout));
`ifdef SERIAL_ADD_OVF_EN
        check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`endif
        @(posedge clk);
        #1;
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        check({tag, "_sum_held"}, 32'(sum), 32'(exp_sum));
        if (exp_ovf === 1'bx) $display("note: unexpected ovf argument");
    endtask

    initial begin
        int cyc;
        int ndone;
        int last_done;
        int nd;

        rst   = 1'b0;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        cin   = 1'b0;

        // Reset state, observed while reset is asserted.
        #5 rst = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum",  32'(sum),  32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_fa_abc", 32'({fa_a, fa_b, fa_c}), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_no_start_busy", 32'(busy), 32'd0);

        run_op("add_35_4a", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op("add_a5_5a_c1", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);

        // Start held high: back-to-back operations, operands disturbed in RUN.
        @(negedge clk);
        op_a      = 8'h10;
        op_b      = 8'h20;
        cin       = 1'b1;
        start     = 1'b1;
        cyc       = 0;
        ndone     = 0;
        last_done = 0;
        while (ndone < 3 && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) begin
                check("cont_sum", 32'(sum), 32'h31);
                check("cont_cout", 32'(cout), 32'd0);
                if (ndone > 0) check("cont_period", 32'(cyc - last_done), 32'd10);
                last_done = cyc;
                ndone++;
            end
            if (busy) begin
                op_a = 8'hF0;
                op_b = 8'h0F;
                cin  = 1'b0;
            end else begin
                op_a = 8'h10;
                op_b = 8'h20;
                cin  = 1'b1;
            end
        end
        check("cont_done_count", 32'(ndone), 32'd3);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in the middle of RUN aborts the operation.
        @(negedge clk);
        op_a  = 8'h55;
        op_b  = 8'h0F;
        cin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #10;
        check("abort_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sum",  32'(sum),  32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_fa_abc", 32'({fa_a, fa_b, fa_c}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        nd  = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) nd++;
        end
        check("abort_no_done", 32'(nd), 32'd0);

        run_op("after_abort", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
